// File: rtl/golomb_search_controller.sv
// golomb_search_controller: walks control through the mark_counter chain and tracks the best ruler.
// Define GOLOMB_CTRL_WATCHDOG_EN to bound the wait for the ready acknowledge.
`ifndef NUMPOSITIONS
`define NUMPOSITIONS 3
`endif
`ifndef PositionValueBitMax
`define PositionValueBitMax 7
`endif
`ifndef PositionNumberBitMax
`define PositionNumberBitMax 2
`endif
`ifndef MAXVALUE
`define MAXVALUE 255
`endif

module golomb_search_controller #(
    parameter int NUMPOSITIONS  = `NUMPOSITIONS,
    parameter int VW            = `PositionValueBitMax + 1,
    parameter int LW            = `PositionNumberBitMax + 1,
    parameter int START_LEVEL   = 1,
    parameter int INITIAL_LIMIT = `MAXVALUE,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [LW-1:0]                  enabled,
    output logic                           request,
    input  logic                           ready_all,
    input  logic [(NUMPOSITIONS+1)*LW-1:0] next_enabled_all,
    input  logic                           success,
    input  logic [(NUMPOSITIONS+1)*VW-1:0] marks_in,
    output logic [VW-1:0]                  limit,
    output logic [(NUMPOSITIONS+1)*VW-1:0] best_marks,
    output logic [15:0]                    solutions
);

    localparam int MW = (NUMPOSITIONS + 1) * VW;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_ACK, WAIT_DONE, EVAL, FINISH
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   enabled_q, enabled_d;
    logic [VW-1:0]   limit_q, limit_d;
    logic [MW-1:0]   best_marks_q, best_marks_d;
    logic [15:0]     solutions_q, solutions_d;
    logic            error_q, error_d;
    logic [LW-1:0]   nxt;
    logic [VW-1:0]   leafval;
    logic            wd_expired;

    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be at least 1");
    end

    assign nxt     = next_enabled_all[enabled_q*LW +: LW];
    assign leafval = marks_in[NUMPOSITIONS*VW +: VW];

`ifdef GOLOMB_CTRL_WATCHDOG_EN
    localparam int WDW = $clog2(ACK_TIMEOUT + 1);
    logic [WDW-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = '0;
        if (state_q == WAIT_ACK) wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end

    assign wd_expired = (wd_q == WDW'(ACK_TIMEOUT - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            enabled_q    <= '0;
            limit_q      <= VW'(INITIAL_LIMIT);
            best_marks_q <= '0;
            solutions_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            enabled_q    <= enabled_d;
            limit_q      <= limit_d;
            best_marks_q <= best_marks_d;
            solutions_q  <= solutions_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        enabled_d    = enabled_q;
        limit_d      = limit_q;
        best_marks_d = best_marks_q;
        solutions_d  = solutions_q;
        error_d      = error_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d     = ISSUE;
                enabled_d   = LW'(START_LEVEL);
                limit_d     = VW'(INITIAL_LIMIT);
                solutions_d = '0;
                error_d     = 1'b0;
            end
            ISSUE: if (ready_all) state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (!ready_all) begin
                    state_d = WAIT_DONE;
                end else if (wd_expired) begin
                    error_d   = 1'b1;
                    enabled_d = '0;
                    state_d   = FINISH;
                end
            end
            WAIT_DONE: if (ready_all) state_d = EVAL;
            EVAL: begin
                // a hit is recorded even when it is the last step
                if (success) begin
                    best_marks_d = marks_in;
                    if (solutions_q != 16'hFFFF) solutions_d = solutions_q + 16'd1;
                    limit_d = (leafval == '0) ? '0 : leafval - 1'b1;
                end
                if (nxt > LW'(NUMPOSITIONS)) begin
                    error_d   = 1'b1;
                    enabled_d = '0;
                    state_d   = FINISH;
                end else if (nxt == '0) begin
                    enabled_d = '0;
                    state_d   = FINISH;
                end else begin
                    enabled_d = nxt;
                    state_d   = ISSUE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        request = 1'b0;
        unique case (state_q)
            ISSUE: begin
                busy    = 1'b1;
                request = ready_all;
            end
            WAIT_ACK, WAIT_DONE, EVAL: busy = 1'b1;
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    assign enabled    = enabled_q;
    assign limit      = limit_q;
    assign best_marks = best_marks_q;
    assign solutions  = solutions_q;
    assign error      = error_q;

endmodule

// File: tb/tb_golomb_search_controller.sv
// tb_golomb_search_controller: mock mark chain driving the search controller.
// Table of search steps plus hand sequences for reset, abort and ack stall.
module tb_golomb_search_controller;

    localparam int NP = 3;
    localparam int VW = 8;
    localparam int LW = 3;

    logic                  clock;
    logic                  reset;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [LW-1:0]         enabled;
    logic                  request;
    logic                  ready_all;
    logic [(NP+1)*LW-1:0]  next_enabled_all;
    logic                  success;
    logic [(NP+1)*VW-1:0]  marks_in;
    logic [VW-1:0]         limit;
    logic [(NP+1)*VW-1:0]  best_marks;
    logic [15:0]           solutions;

    golomb_search_controller #(
        .NUMPOSITIONS(NP),
        .VW(VW),
        .LW(LW),
        .START_LEVEL(1),
        .INITIAL_LIMIT(255),
        .ACK_TIMEOUT(15)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .busy(busy),
        .done(done),
        .error(error),
        .enabled(enabled),
        .request(request),
        .ready_all(ready_all),
        .next_enabled_all(next_enabled_all),
        .success(success),
        .marks_in(marks_in),
        .limit(limit),
        .best_marks(best_marks),
        .solutions(solutions)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          first;
        logic [2:0]  level;
        logic [2:0]  nxt;
        bit          success;
        logic [31:0] marks;
    } vec_t;

    typedef struct {
        logic [7:0]  limit;
        logic [15:0] sol;
        logic [31:0] best;
        bit          err;
        bit          fin;
        logic [2:0]  nxt;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        sbq[$];
    logic [7:0]  m_limit;
    logic [15:0] m_sol;
    logic [31:0] m_best;
    bit          m_err;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_step(input vec_t v);
        exp_t       e;
        int         n;
        logic [7:0] leaf;
        if (v.first) begin
            @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            m_limit = 8'd255;
            m_sol   = 16'd0;
            m_err   = 1'b0;
            chk("start_busy", busy, 1);
            chk("start_limit", limit, 255);
            chk("start_solutions", solutions, 0);
            chk("start_error", error, 0);
        end
        n = 0;
        while (request !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("request_seen", request, 1);
        chk("request_level", enabled, v.level);
        @(negedge clock);
        chk("request_pulse", request, 0);
        ready_all = 1'b0;
        @(negedge clock);
        @(negedge clock);
        for (int k = 0; k <= NP; k++)
            next_enabled_all[k*LW +: LW] = (k == int'(v.level)) ? v.nxt : 3'd6;
        success   = v.success;
        marks_in  = v.marks;
        ready_all = 1'b1;
        if (v.success) begin
            m_best = v.marks;
            if (m_sol != 16'hFFFF) m_sol = m_sol + 16'd1;
            leaf = v.marks[31:24];
            m_limit = (leaf == 8'd0) ? 8'd0 : leaf - 8'd1;
        end
        if (v.nxt > 3'd3) m_err = 1'b1;
        e.limit = m_limit;
        e.sol   = m_sol;
        e.best  = m_best;
        e.err   = m_err;
        e.fin   = (v.nxt == 3'd0) || (v.nxt > 3'd3);
        e.nxt   = v.nxt;
        sbq.push_back(e);
        @(negedge clock);
        chk("eval_busy", busy, 1);
        @(negedge clock);
        success = 1'b0;
        e = sbq.pop_front();
        chk("limit", limit, e.limit);
        chk("solutions", solutions, e.sol);
        chk("best_marks", best_marks, e.best);
        chk("error", error, e.err);
        if (e.fin) begin
            chk("done_pulse", done, 1);
            chk("finish_busy", busy, 0);
            chk("finish_enabled", enabled, 0);
            @(negedge clock);
            chk("done_clears", done, 0);
            chk("idle_busy", busy, 0);
        end else begin
            chk("reissue", request, 1);
            chk("next_level", enabled, e.nxt);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_limit = 8'd255;
        m_sol   = 16'd0;
        m_best  = 32'd0;
        m_err   = 1'b0;
    endtask

    initial begin
        int   done_seen;
        int   done_at;
        vec_t v;

        reset            = 1'b1;
        start            = 1'b0;
        ready_all        = 1'b1;
        success          = 1'b0;
        marks_in         = '0;
        next_enabled_all = '0;
        m_limit = 8'd255;
        m_sol   = 16'd0;
        m_best  = 32'd0;
        m_err   = 1'b0;

        tbl[0]  = '{1'b1, 3'd1, 3'd2, 1'b0, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'd2, 3'd3, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 3'd3, 3'd0, 1'b0, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 3'd1, 3'd2, 1'b0, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 3'd2, 3'd3, 1'b0, 32'hDEADBEEF};
        tbl[5]  = '{1'b0, 3'd3, 3'd3, 1'b1, 32'h06040100};
        tbl[6]  = '{1'b0, 3'd3, 3'd0, 1'b1, 32'h05040100};
        tbl[7]  = '{1'b1, 3'd1, 3'd3, 1'b0, 32'hDEADBEEF};
        tbl[8]  = '{1'b0, 3'd3, 3'd0, 1'b1, 32'h00000000};
        tbl[9]  = '{1'b1, 3'd1, 3'd5, 1'b0, 32'hDEADBEEF};
        tbl[10] = '{1'b1, 3'd1, 3'd0, 1'b1, 32'h07030200};
        tbl[11] = '{1'b1, 3'd1, 3'd2, 1'b0, 32'hDEADBEEF};

        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_request", request, 0);
        end
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_enabled", enabled, 0);
        chk("reset_limit", limit, 255);
        chk("reset_best", best_marks, 0);
        chk("reset_solutions", solutions, 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) do_step(tbl[i]);

        // acknowledge never arrives: ready_all stays high
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("stall_request", request, 1);
        done_seen = 0;
        done_at   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (done === 1'b1 && done_seen == 0) done_at = i;
            if (done === 1'b1) done_seen++;
        end
`ifdef GOLOMB_CTRL_WATCHDOG_EN
        chk("wd_done_once", done_seen, 1);
        chk("wd_latency", (done_at >= 15 && done_at <= 17), 1);
        chk("wd_error", error, 1);
        chk("wd_busy", busy, 0);
`else
        chk("stall_no_done", done_seen, 0);
        chk("stall_busy", busy, 1);
        chk("stall_no_request", request, 0);
        chk("stall_error", error, 0);
`endif
        apply_reset();

        // abort from WAIT_DONE
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("abort_request", request, 1);
        @(negedge clock);
        ready_all = 1'b0;
        @(negedge clock);
        chk("abort_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", busy, 0);
        chk("abort_enabled", enabled, 0);
        chk("abort_limit", limit, 255);
        chk("abort_request_low", request, 0);
        reset     = 1'b0;
        ready_all = 1'b1;
        m_limit = 8'd255;
        m_sol   = 16'd0;
        m_best  = 32'd0;
        m_err   = 1'b0;
        done_seen = 0;
        if (done === 1'b1) done_seen++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done === 1'b1) done_seen++;
            if (request === 1'b1) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);

        v = tbl[11];
        do_step(v);
        v = '{1'b0, 3'd2, 3'd0, 1'b1, 32'h09080300};
        do_step(v);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
